// File: rtl/clk_monitor_pkg.sv
// Shared definitions for the clock lock monitor: FSM encoding, STATUS bit
// positions and the period tolerance check.
package clk_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    ACQUIRE   = 2'd2,
    LOCK      = 2'd3
  } mon_state_t;

  localparam int STAT_STOPPED = 0;
  localparam int STAT_RANGE   = 1;
  localparam int STAT_LOSS    = 2;

  // 17-bit window so EXP+TOL cannot wrap; a negative lower bound clamps to 0.
  function automatic logic in_tolerance(input logic [15:0] period,
                                        input logic [15:0] exp_period,
                                        input logic [15:0] tol);
    logic [16:0] lo;
    logic [16:0] hi;
    hi = {1'b0, exp_period} + {1'b0, tol};
    lo = (tol > exp_period) ? 17'd0 : ({1'b0, exp_period} - {1'b0, tol});
    return ({1'b0, period} >= lo) && ({1'b0, period} <= hi);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous input followed by a third flop
// used to detect rising edges in the local clock domain.
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_lock_monitor.sv
// Measures the period of an asynchronous clock/toggle in CLK cycles and
// tracks lock, stop and out-of-range conditions with sticky status bits.
module clk_lock_monitor
  import clk_monitor_pkg::*;
#(
  parameter logic [15:0] EXP_PERIOD = 16'd10,
  parameter logic [15:0] TOLERANCE  = 16'd1,
  parameter int unsigned LOCK_COUNT = 4,
  parameter logic [15:0] TIMEOUT    = 16'd64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        MON_IN,
  input  logic        CLR_STATUS,
  output logic        LOCKED,
  output logic [15:0] PERIOD,
  output logic        PERIOD_VALID,
  output logic [2:0]  STATUS
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  mon_state_t  state_q;
  logic [15:0] cnt_q;
  logic [15:0] period_q;
  logic [3:0]  good_q;
  logic        locked_q;
  logic        valid_q;
  logic [2:0]  status_q;
  logic [2:0]  status_d;
  logic [2:0]  status_set;

  logic        rise;
  logic        meas_ok;
  logic        measuring;
  logic        timeout_hit;
  logic [15:0] cnt_inc;

  sync_edge_detect u_sync (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .d_i    (MON_IN),
    .rise_o (rise)
  );

  assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign meas_ok     = in_tolerance(cnt_q, EXP_PERIOD, TOLERANCE);
  assign measuring   = EN && ((state_q == ACQUIRE) || (state_q == LOCK));
  // Equality rather than >= so a saturated counter in WAIT_EDGE fires only once.
  assign timeout_hit = EN && (state_q != IDLE) && !rise && (cnt_q == TIMEOUT);

  // New events win over a simultaneous clear.
  always_comb begin
    status_set = '0;
    if (measuring && rise && !meas_ok) begin
      status_set[STAT_RANGE] = 1'b1;
      status_set[STAT_LOSS]  = (state_q == LOCK);
    end
    if (timeout_hit) begin
      status_set[STAT_STOPPED] = 1'b1;
      if (state_q == LOCK) status_set[STAT_LOSS] = 1'b1;
    end
    status_d = (status_q & ~{3{CLR_STATUS}}) | status_set;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      status_q <= '0;
    end else begin
      status_q <= status_d;
      valid_q  <= 1'b0;
      if (!EN) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        good_q   <= '0;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= WAIT_EDGE;
            cnt_q   <= '0;
            good_q  <= '0;
          end
          WAIT_EDGE: begin
            if (rise) begin
              state_q <= ACQUIRE;
              cnt_q   <= 16'd1;
              good_q  <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          ACQUIRE, LOCK: begin
            if (rise) begin
              cnt_q    <= 16'd1;
              period_q <= cnt_q;
              valid_q  <= 1'b1;
              if (!meas_ok) begin
                state_q  <= ACQUIRE;
                good_q   <= '0;
                locked_q <= 1'b0;
              end else if (state_q == ACQUIRE) begin
                good_q <= good_q + 4'd1;
                if ((good_q + 4'd1) >= LOCK_CNT) begin
                  state_q  <= LOCK;
                  locked_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_inc;
              if (timeout_hit) begin
                state_q  <= WAIT_EDGE;
                good_q   <= '0;
                locked_q <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign LOCKED       = locked_q;
  assign PERIOD       = period_q;
  assign PERIOD_VALID = valid_q;
  assign STATUS       = status_q;

endmodule

// File: tb/tb_clk_lock_monitor.sv
// Table-driven bench: each record places one MON_IN rising edge a given number
// of CLK cycles after the previous one; expected strobes go to a scoreboard.
module tb_clk_lock_monitor;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic        MON_IN;
  logic        CLR_STATUS;
  logic        LOCKED;
  logic [15:0] PERIOD;
  logic        PERIOD_VALID;
  logic [2:0]  STATUS;

  always #5 CLK = ~CLK;

  clk_lock_monitor dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .EN           (EN),
    .MON_IN       (MON_IN),
    .CLR_STATUS   (CLR_STATUS),
    .LOCKED       (LOCKED),
    .PERIOD       (PERIOD),
    .PERIOD_VALID (PERIOD_VALID),
    .STATUS       (STATUS)
  );

  typedef struct {
    int          gap;
    bit          pv;
    logic [15:0] period;
    bit          locked;
    logic [2:0]  status;
    bit          clr;
  } vec_t;

  typedef struct {
    logic [15:0] period;
    bit          locked;
    logic [2:0]  status;
    int          due;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int checks        = 0;
  int errors        = 0;
  int cyc           = 0;
  int last_rise_cyc = -1000;
  int txn           = 0;
  bit clr_pending   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One CLK cycle: sample at the falling edge, then drive MON_IN and any
  // CLR_STATUS pulse scheduled to coincide with the last edge's detection.
  task automatic tick();
    int   el;
    exp_t e;
    @(negedge CLK);
    cyc++;
    if (RST_N === 1'b1 && PERIOD_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pv: got strobe with PERIOD=%0d, expected none (cycle %0d)", PERIOD, cyc);
      end else begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: PERIOD=%0d LOCKED=%0b STATUS=%03b cycle %0d", txn, PERIOD, LOCKED, STATUS, cyc);
        chk("pv_period", 32'(PERIOD), 32'(e.period));
        chk("pv_locked", 32'(LOCKED), 32'(e.locked));
        chk("pv_status", 32'(STATUS), 32'(e.status));
        chk("pv_latency", cyc, e.due);
      end
    end
    el = cyc - last_rise_cyc;
    MON_IN = (el <= 1);
    if (clr_pending && el == 2) begin
      CLR_STATUS = 1'b1;
    end else if (clr_pending && el == 3) begin
      CLR_STATUS  = 1'b0;
      clr_pending = 1'b0;
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic add(input int gap, input bit pv, input int period, input bit locked,
                     input logic [2:0] status, input bit clr = 1'b0);
    vec_t v;
    v.gap    = gap;
    v.pv     = pv;
    v.period = 16'(period);
    v.locked = locked;
    v.status = status;
    v.clr    = clr;
    vecs.push_back(v);
  endtask

  // Rise is seen by the DUT three edges later; the strobe follows that edge.
  task automatic run_table();
    exp_t e;
    foreach (vecs[i]) begin
      while (cyc - last_rise_cyc < vecs[i].gap) tick();
      MON_IN        = 1'b1;
      last_rise_cyc = cyc;
      clr_pending   = vecs[i].clr;
      if (vecs[i].pv) begin
        e.period = vecs[i].period;
        e.locked = vecs[i].locked;
        e.status = vecs[i].status;
        e.due    = cyc + 3;
        sb.push_back(e);
      end
    end
    vecs.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N      = 1'b0;
    EN         = 1'b0;
    MON_IN     = 1'b0;
    CLR_STATUS = 1'b0;
    wait_ticks(3);
    chk("rst_locked", 32'(LOCKED), 0);
    chk("rst_period", 32'(PERIOD), 0);
    chk("rst_pv", 32'(PERIOD_VALID), 0);
    chk("rst_status", 32'(STATUS), 0);
    RST_N = 1'b1;
    EN    = 1'b1;

    // Lock, tolerance edges 9/11, a 12 while locked, then relock.
    add(6, 0, 0, 0, 3'b000);
    add(10, 1, 10, 0, 3'b000);
    add(10, 1, 10, 0, 3'b000);
    add(10, 1, 10, 0, 3'b000);
    add(10, 1, 10, 1, 3'b000);
    add(9, 1, 9, 1, 3'b000);
    add(11, 1, 11, 1, 3'b000);
    add(12, 1, 12, 0, 3'b110);
    add(10, 1, 10, 0, 3'b110);
    add(10, 1, 10, 0, 3'b110);
    add(10, 1, 10, 0, 3'b110);
    add(10, 1, 10, 1, 3'b110);
    run_table();
    wait_ticks(5);
    chk("drain_lock", sb.size(), 0);

    chk("locked_before_clr", 32'(LOCKED), 1);
    CLR_STATUS = 1'b1;
    tick();
    CLR_STATUS = 1'b0;
    chk("clr_alone", 32'(STATUS), 0);

    // Stop: MON_IN held low while locked.
    while (STATUS[0] !== 1'b1 && cyc - last_rise_cyc < 200) tick();
    chk("stop_latency", cyc - last_rise_cyc, 67);
    chk("stop_status", 32'(STATUS), 32'(3'b101));
    chk("stop_locked", 32'(LOCKED), 0);

    // Restart from WAIT_EDGE; clear collides with an out-of-range detection.
    add(6, 0, 0, 0, 3'b000);
    add(10, 1, 10, 0, 3'b101);
    add(20, 1, 20, 0, 3'b010, 1'b1);
    add(10, 1, 10, 0, 3'b010);
    run_table();
    wait_ticks(5);
    chk("drain_clr", sb.size(), 0);
    CLR_STATUS = 1'b1;
    tick();
    CLR_STATUS = 1'b0;
    chk("clr_later", 32'(STATUS), 0);

    add(10, 1, 10, 0, 3'b000);
    add(10, 1, 10, 0, 3'b000);
    add(10, 1, 10, 1, 3'b000);
    run_table();
    wait_ticks(4);
    chk("drain_relock", sb.size(), 0);

    // Asynchronous reset in the middle of a period.
    chk("locked_before_rst", 32'(LOCKED), 1);
    RST_N = 1'b0;
    #1;
    chk("midrst_locked", 32'(LOCKED), 0);
    chk("midrst_period", 32'(PERIOD), 0);
    chk("midrst_pv", 32'(PERIOD_VALID), 0);
    chk("midrst_status", 32'(STATUS), 0);
    wait_ticks(2);
    RST_N = 1'b1;

    add(7, 0, 0, 0, 3'b000);
    add(10, 1, 10, 0, 3'b000);
    add(10, 1, 10, 0, 3'b000);
    add(10, 1, 10, 0, 3'b000);
    add(10, 1, 10, 1, 3'b000);
    run_table();
    wait_ticks(4);
    chk("drain_after_rst", sb.size(), 0);

    // Enable dropped while locked; edges keep arriving with no strobes.
    chk("locked_before_en", 32'(LOCKED), 1);
    EN = 1'b0;
    tick();
    chk("en_drop_locked", 32'(LOCKED), 0);
    add(10, 0, 0, 0, 3'b000);
    add(10, 0, 0, 0, 3'b000);
    add(10, 0, 0, 0, 3'b000);
    run_table();
    wait_ticks(6);
    chk("disabled_locked", 32'(LOCKED), 0);
    EN = 1'b1;
    add(10, 0, 0, 0, 3'b000);
    add(10, 1, 10, 0, 3'b000);
    run_table();
    wait_ticks(5);
    chk("drain_en", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_lock_monitor.md
CLK_LOCK_MONITOR -- requirements
Module: clk_lock_monitor

Interface
REQ-001 SHALL have parameter EXP_PERIOD, default 16'd10, meaning the expected monitored-signal period in CLK cycles.
REQ-002 SHALL have parameter TOLERANCE, default 16'd1, meaning the maximum allowed |measured - EXP_PERIOD| in CLK cycles.
REQ-003 SHALL have parameter LOCK_COUNT, default 4, meaning the number of consecutive in-tolerance periods required to lock, range 1..15.
REQ-004 SHALL have parameter TIMEOUT, default 16'd64, meaning the CLK cycles without a monitored rising edge that declare the input stopped; TIMEOUT > EXP_PERIOD + TOLERANCE.
REQ-005 SHALL have port CLK, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-006 SHALL have port RST_N, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port EN, input, 1, monitor enable, synchronous to CLK.
REQ-008 SHALL have port MON_IN, input, 1, the monitored clock or toggle (for example a DCM CLKFX output), asynchronous to CLK.
REQ-009 SHALL have port CLR_STATUS, input, 1, a one-cycle pulse that clears the sticky STATUS bits.
REQ-010 SHALL have port LOCKED, output, 1, high while in state LOCK.
REQ-011 SHALL have port PERIOD, output, 16, the last measured period in CLK cycles.
REQ-012 SHALL have port PERIOD_VALID, output, 1, a one-cycle strobe marking a PERIOD update.
REQ-013 SHALL have port STATUS, output, 3, with fields [0] stopped (sticky), [1] out-of-range seen (sticky), [2] lock lost (sticky).

Function
REQ-014 SHALL synchronise MON_IN through two flops, then detect rising edges with a third flop; an edge is registered 3 CLK cycles after MON_IN rises.
REQ-015 SHALL require MON_IN to be high for at least 2 CLK cycles and low for at least 2 CLK cycles; faster inputs are outside the contract.
REQ-016 SHALL run a 16-bit period counter that increments every cycle, saturates at 16'hFFFF, and loads 1 on each detected edge.
REQ-017 SHALL, on each detected edge except the first after reset or after EN rises, load PERIOD with the counter value and pulse PERIOD_VALID for exactly 1 cycle, in the cycle after the edge is registered.
REQ-018 SHALL treat a period as in-tolerance when EXP_PERIOD-TOLERANCE <= PERIOD <= EXP_PERIOD+TOLERANCE, using unsigned 17-bit compare with no wrap; a lower bound below 0 clamps to 0.
REQ-019 SHALL implement states IDLE, WAIT_EDGE, ACQUIRE and LOCK.
REQ-020 SHALL enter IDLE from any state when EN=0; in IDLE the counters are cleared and no strobes are produced.
REQ-021 SHALL move IDLE -> WAIT_EDGE when EN=1, and WAIT_EDGE -> ACQUIRE on the first edge, with that edge producing no PERIOD_VALID.
REQ-022 SHALL, in ACQUIRE, increment the 4-bit good-count on each in-tolerance period and clear it on each out-of-range period; reaching LOCK_COUNT SHALL move to LOCK in the same update.
REQ-023 SHALL, in LOCK, move to ACQUIRE on an out-of-range period, with good-count 0, and set STATUS[2] and STATUS[1].
REQ-024 SHALL, when the counter reaches TIMEOUT in WAIT_EDGE, ACQUIRE or LOCK, set STATUS[0] and go to WAIT_EDGE; from LOCK it SHALL also set STATUS[2].
REQ-025 SHALL set STATUS[1] on any out-of-range period, in any state.
REQ-026 SHALL give priority to a set over CLR_STATUS when both occur in the same cycle, so the bit stays set.
REQ-027 SHALL drive LOCKED from a register, so it rises in the same cycle as the PERIOD_VALID that completes LOCK_COUNT and falls in the cycle after the fault is registered.

Reset
REQ-028 SHALL, while RST_N=0, asynchronously force state IDLE, LOCKED=0, PERIOD=0, PERIOD_VALID=0, STATUS=3'b000, all counters 0 and all synchroniser flops 0.
REQ-029 SHALL treat reset release like EN rising: the first edge after reset produces no PERIOD_VALID.
REQ-030 SHALL, on reset mid-measurement, discard the partial period.

Structure
REQ-031 SHALL place the state encoding (IDLE=2'd0, WAIT_EDGE=2'd1, ACQUIRE=2'd2, LOCK=2'd3) and the STATUS bit indices in a shared package, clk_monitor_pkg.
REQ-032 SHALL implement the synchroniser and edge detector as one sub-module, sync_edge_detect.

Verification
REQ-033 SHALL cover lock: MON_IN period 10 CLK, EN=1 -> PERIOD_VALID pulses with PERIOD=10, LOCKED rises on the 4th valid period.
REQ-034 SHALL cover the tolerance edges: periods 9 and 11 -> lock is kept; a single period of 12 while locked -> LOCKED falls, STATUS=3'b110, and relock occurs after 4 more good periods.
REQ-035 SHALL cover stop: MON_IN held low while locked -> after 64 cycles without an edge, STATUS[0] and STATUS[2] are set, LOCKED=0, state is WAIT_EDGE, and the first new edge gives no PERIOD_VALID.
REQ-036 SHALL cover simultaneous events: CLR_STATUS asserted in the same cycle as a new out-of-range detection -> STATUS[1] remains 1; a later CLR_STATUS alone -> STATUS=0.
REQ-037 SHALL cover reset and enable: RST_N pulsed low mid-period while locked -> all outputs are 0 immediately; dropping EN while locked -> LOCKED=0 next cycle with no strobes until EN returns.
